fifo_mem_bank: RTL and testbench
================================

# fifo_mem_bank

Parametrised storage array for the FIFO datapath, sitting between write-side and read-side pointer logic.
- Adds over the current FIFO memory: byte-lane write enables, selectable registered read with valid strobe and write-first bypass, and a sequenced, re-triggerable clear state machine in place of an all-entries reset loop.
- Reports dropped writes so the pointer logic and scoreboard can flag protocol errors.

## Interface
- DEPTH, 32, number of entries; must be ≤ 2**ADDR
- WIDTH, 32, data width in bits; must be a multiple of BYTE_W
- ADDR, 5, address width
- BYTE_W, 8, bits per write-enable lane; NB = WIDTH/BYTE_W lanes
- REG_OUT, 1, 1 = registered read (1-cycle latency), 0 = combinational read
- CLR_ON_RESET, 1, 1 = run clear sequence after reset, 0 = enter RUN directly
- clk  in  1  clock; all state on rising edge
- reset_b  in  1  asynchronous, active-low reset
- clear  in  1  synchronous request to re-zero the array
- write  in  1  write request
- wfull  in  1  FIFO full; blocks write
- wbe  in  NB  per-lane write enable
- waddr  in  ADDR  write address
- wdata  in  WIDTH  write data
- read  in  1  read request (used only when REG_OUT=1)
- raddr  in  ADDR  read address
- rdata  out  WIDTH  read data
- rvalid  out  1  rdata valid
- init_done  out  1  array initialised; accesses accepted
- wr_drop  out  1  one-cycle pulse: previous-cycle write rejected

## Operation
- Reset values: rdata 0, rvalid 0, wr_drop 0, init cursor 0. init_done is 0 when CLR_ON_RESET=1, 1 otherwise. State is INIT when CLR_ON_RESET=1, RUN otherwise. Array contents are not reset.
- INIT state: one entry zeroed per cycle at the cursor address 0..DEPTH-1. After entry DEPTH-1 is written: go to RUN, set init_done=1, reset cursor to 0.
- RUN state: clear=1 moves to INIT, clears init_done and resets cursor to 0.
- Clear during INIT restarts the cursor at 0.
- A write coinciding with clear is dropped.
- Accepted write: RUN & write & ~wfull & waddr<DEPTH. Only lanes with wbe[i]=1 are updated; other lanes keep their contents.
- wbe=0 on an accepted write is a no-op, not a drop.
- Dropped write: write & (wfull | state≠RUN | clear | waddr≥DEPTH). Sets wr_drop=1 for the following cycle only; the array is unchanged.
- Read with REG_OUT=0:
  - rdata = array[raddr], combinational.
  - rdata = 0 if raddr≥DEPTH.
  - rvalid = init_done.
- Read with REG_OUT=1:
  - read accepted only in RUN.
  - Next cycle: rdata = array[raddr] (0 if raddr≥DEPTH), rvalid=1.
  - Otherwise rvalid=0 and rdata holds its last value.
- Collision (REG_OUT=1, accepted read and accepted write, raddr==waddr): write-first. rdata = old word with the enabled lanes replaced by wdata.
- Reads during INIT: rvalid=0 in both modes.

## Timing
- INIT lasts exactly DEPTH cycles. init_done rises on the DEPTH-th rising edge after reset release or after the edge sampling clear.
- Write latency 1: data is visible to a combinational read one cycle after the write edge.
- Registered read latency 1. rvalid is a single-cycle pulse per read; back-to-back reads give back-to-back valid beats.
- wr_drop is asserted exactly one cycle after the offending request edge.
- Async reset mid-INIT or mid-RUN returns all outputs to reset values immediately. The clear sequence restarts from 0.

## Structure
- Package fifo_mem_pkg holds:
  - state enum typedef: ST_INIT, ST_RUN
  - NB and lane-merge helper function
  - parameter legality checks: WIDTH % BYTE_W == 0, DEPTH ≤ 2**ADDR
- One sub-module, fifo_mem_init_seq: INIT/RUN FSM, clear cursor and init_done. It drives the internal write port mux (init zero-write vs user write).

## Test plan
- Reset release, CLR_ON_RESET=1, DEPTH=32 -> init_done low 32 cycles, high on edge 32; write at cycle 5 -> wr_drop=1 at cycle 6, entry unchanged.
- After init: write addr 3, wdata 0xAABBCCDD, wbe 0b0101 -> registered read of addr 3 returns 0x00BB00DD with rvalid pulse 1 cycle later.
- Same-cycle write addr 7 (0x12345678, wbe 0xF) and read addr 7 with REG_OUT=1 -> rdata 0x12345678 next cycle.
- write with wfull=1, waddr 4 -> wr_drop one-cycle pulse; later read of addr 4 returns 0.
- Fill entries 0..31 with nonzero data, pulse clear -> init_done low for 32 cycles, then reads of every entry return 0.
- Assert reset_b low mid-INIT at cursor 10 -> outputs reset immediately; after release the sequence restarts at entry 0 and takes the full 32 cycles.

Source files
------------

// File: rtl/fifo_mem_pkg.sv
// Shared types and helpers for the FIFO storage bank: FSM state, lane count,
// byte-lane merge and parameter legality.
package fifo_mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Widest word the lane-merge helper handles; callers size-cast in and out.
    localparam int MAX_W = 256;

    function automatic int calc_nb(input int width, input int byte_w);
        return width / byte_w;
    endfunction

    function automatic bit params_ok(input int depth, input int width, input int addr,
                                     input int byte_w);
        return (byte_w > 0) && (width > 0) && (width % byte_w == 0) && (width <= MAX_W) &&
               (depth > 0) && (addr > 0) && (addr < 32) &&
               (longint'(depth) <= (longint'(1) << addr));
    endfunction

    // Bits in lanes with be set come from new_word, the rest from old_word.
    function automatic logic [MAX_W-1:0] lane_merge(input logic [MAX_W-1:0] old_word,
                                                    input logic [MAX_W-1:0] new_word,
                                                    input logic [MAX_W-1:0] be,
                                                    input int               byte_w);
        logic [MAX_W-1:0] merged;
        for (int i = 0; i < MAX_W; i++) begin
            merged[i] = be[i / byte_w] ? new_word[i] : old_word[i];
        end
        return merged;
    endfunction

endpackage

// File: rtl/fifo_mem_init_seq.sv
// INIT/RUN sequencer: walks a zeroing cursor over the array after reset or clear
// and muxes the array write port between the zero-fill and the user write.
module fifo_mem_init_seq
    import fifo_mem_pkg::*;
#(
    parameter int   DEPTH        = 32,
    parameter int   WIDTH        = 32,
    parameter int   ADDR         = 5,
    parameter int   BYTE_W       = 8,
    parameter int   CLR_ON_RESET = 1,
    localparam int  NB           = WIDTH / BYTE_W
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             i_clear,
    input  logic             i_write,
    input  logic             i_wfull,
    input  logic [NB-1:0]    i_wbe,
    input  logic [ADDR-1:0]  i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic             o_init_done,
    output logic             o_mem_we,
    output logic [NB-1:0]    o_mem_be,
    output logic [ADDR-1:0]  o_mem_addr,
    output logic [WIDTH-1:0] o_mem_wdata,
    output logic             o_wr_accept,
    output logic             o_wr_reject
);

    localparam state_e        RST_STATE   = (CLR_ON_RESET != 0) ? ST_INIT : ST_RUN;
    localparam logic [ADDR-1:0] CURSOR_LAST = ADDR'(DEPTH - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [ADDR-1:0] r_cursor;
    logic [ADDR-1:0] w_cursor_nxt;
    logic            w_run;
    logic            w_waddr_ok;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state  <= RST_STATE;
            r_cursor <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cursor <= w_cursor_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cursor_nxt = r_cursor;
        unique case (r_state)
            ST_INIT: begin
                if (i_clear) begin
                    w_cursor_nxt = '0;
                end else if (r_cursor == CURSOR_LAST) begin
                    w_state_nxt  = ST_RUN;
                    w_cursor_nxt = '0;
                end else begin
                    w_cursor_nxt = r_cursor + 1'b1;
                end
            end
            ST_RUN: begin
                if (i_clear) begin
                    w_state_nxt  = ST_INIT;
                    w_cursor_nxt = '0;
                end
            end
        endcase
    end

    always_comb begin
        w_run       = (r_state == ST_RUN);
        w_waddr_ok  = (int'(i_waddr) < DEPTH);
        o_init_done = w_run;
        o_wr_accept = w_run & i_write & ~i_wfull & ~i_clear & w_waddr_ok;
        o_wr_reject = i_write & ~o_wr_accept;
        // While initialising the port belongs to the zero-fill at the cursor.
        o_mem_we    = w_run ? o_wr_accept : 1'b1;
        o_mem_be    = w_run ? i_wbe : '1;
        o_mem_addr  = w_run ? i_waddr : r_cursor;
        o_mem_wdata = w_run ? i_wdata : '0;
    end

endmodule

// File: rtl/fifo_mem_bank.sv
// FIFO storage array with byte-lane writes, optional registered read with
// write-first bypass, sequenced clear and dropped-write reporting.
module fifo_mem_bank
    import fifo_mem_pkg::*;
#(
    parameter int  DEPTH        = 32,
    parameter int  WIDTH        = 32,
    parameter int  ADDR         = 5,
    parameter int  BYTE_W       = 8,
    parameter int  REG_OUT      = 1,
    parameter int  CLR_ON_RESET = 1,
    localparam int NB           = WIDTH / BYTE_W
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             i_clear,
    input  logic             i_write,
    input  logic             i_wfull,
    input  logic [NB-1:0]    i_wbe,
    input  logic [ADDR-1:0]  i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_read,
    input  logic [ADDR-1:0]  i_raddr,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_rvalid,
    output logic             o_init_done,
    output logic             o_wr_drop
);

    if (!params_ok(DEPTH, WIDTH, ADDR, BYTE_W)) begin : g_bad_params
        $error("fifo_mem_bank: illegal DEPTH/WIDTH/ADDR/BYTE_W combination");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_wr_drop;

    logic             w_init_done;
    logic             w_mem_we;
    logic [NB-1:0]    w_mem_be;
    logic [ADDR-1:0]  w_mem_addr;
    logic [WIDTH-1:0] w_mem_wdata;
    logic             w_wr_accept;
    logic             w_wr_reject;
    logic             w_raddr_ok;
    logic [WIDTH-1:0] w_rd_word;

    fifo_mem_init_seq #(
        .DEPTH        (DEPTH),
        .WIDTH        (WIDTH),
        .ADDR         (ADDR),
        .BYTE_W       (BYTE_W),
        .CLR_ON_RESET (CLR_ON_RESET)
    ) u_init_seq (
        .clk         (clk),
        .reset_b     (reset_b),
        .i_clear     (i_clear),
        .i_write     (i_write),
        .i_wfull     (i_wfull),
        .i_wbe       (i_wbe),
        .i_waddr     (i_waddr),
        .i_wdata     (i_wdata),
        .o_init_done (w_init_done),
        .o_mem_we    (w_mem_we),
        .o_mem_be    (w_mem_be),
        .o_mem_addr  (w_mem_addr),
        .o_mem_wdata (w_mem_wdata),
        .o_wr_accept (w_wr_accept),
        .o_wr_reject (w_wr_reject)
    );

    // Array contents are deliberately not reset; the init sequence zeroes them.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int l = 0; l < NB; l++) begin
                if (w_mem_be[l]) begin
                    r_mem[w_mem_addr][l*BYTE_W +: BYTE_W] <= w_mem_wdata[l*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wr_drop <= 1'b0;
        end else begin
            r_wr_drop <= w_wr_reject;
        end
    end

    always_comb begin
        w_raddr_ok = (int'(i_raddr) < DEPTH);
        w_rd_word  = w_raddr_ok ? r_mem[i_raddr] : '0;
    end

    assign o_init_done = w_init_done;
    assign o_wr_drop   = r_wr_drop;

    if (REG_OUT != 0) begin : g_reg_out
        logic [WIDTH-1:0] r_rdata;
        logic             r_rvalid;
        logic             w_rd_accept;
        logic             w_collide;
        logic [WIDTH-1:0] w_byp;
        logic [WIDTH-1:0] w_rd_next;

        assign w_byp = WIDTH'(lane_merge(MAX_W'(w_rd_word), MAX_W'(i_wdata), MAX_W'(i_wbe),
                                         BYTE_W));

        always_comb begin
            w_rd_accept = w_init_done & i_read;
            w_collide   = w_wr_accept & (i_raddr == i_waddr);
            w_rd_next   = w_collide ? w_byp : w_rd_word;
        end

        always_ff @(posedge clk or negedge reset_b) begin
            if (!reset_b) begin
                r_rdata  <= '0;
                r_rvalid <= 1'b0;
            end else begin
                r_rvalid <= w_rd_accept;
                if (w_rd_accept) begin
                    r_rdata <= w_rd_next;
                end
            end
        end

        assign o_rdata  = r_rdata;
        assign o_rvalid = r_rvalid;
    end else begin : g_comb_out
        logic w_unused_read;
        assign w_unused_read = i_read;
        assign o_rdata       = w_rd_word;
        assign o_rvalid      = w_init_done;
    end

endmodule

// File: tb/tb_fifo_mem_bank.sv
// Directed bench for fifo_mem_bank with a read/drop scoreboard checked by a
// free-running monitor on the falling clock edge.
module tb_fifo_mem_bank;

    localparam int DEPTH  = 32;
    localparam int WIDTH  = 32;
    localparam int ADDR   = 5;
    localparam int BYTE_W = 8;
    localparam int NB     = WIDTH / BYTE_W;

    logic             clk = 1'b0;
    logic             reset_b = 1'b0;
    logic             i_clear = 1'b0;
    logic             i_write = 1'b0;
    logic             i_wfull = 1'b0;
    logic [NB-1:0]    i_wbe = '0;
    logic [ADDR-1:0]  i_waddr = '0;
    logic [WIDTH-1:0] i_wdata = '0;
    logic             i_read = 1'b0;
    logic [ADDR-1:0]  i_raddr = '0;
    logic [WIDTH-1:0] o_rdata;
    logic             o_rvalid;
    logic             o_init_done;
    logic             o_wr_drop;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] rd_q[$];
    string            rd_name_q[$];
    string            drop_q[$];

    fifo_mem_bank #(
        .DEPTH        (DEPTH),
        .WIDTH        (WIDTH),
        .ADDR         (ADDR),
        .BYTE_W       (BYTE_W),
        .REG_OUT      (1),
        .CLR_ON_RESET (1)
    ) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .i_clear     (i_clear),
        .i_write     (i_write),
        .i_wfull     (i_wfull),
        .i_wbe       (i_wbe),
        .i_waddr     (i_waddr),
        .i_wdata     (i_wdata),
        .i_read      (i_read),
        .i_raddr     (i_raddr),
        .o_rdata     (o_rdata),
        .o_rvalid    (o_rvalid),
        .o_init_done (o_init_done),
        .o_wr_drop   (o_wr_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every valid beat and every drop pulse must match a queued expectation.
    logic [WIDTH-1:0] mon_exp;
    string            mon_name;
    always @(negedge clk) begin
        if (reset_b) begin
            if (o_rvalid) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rvalid: got rdata %h want no beat", o_rdata);
                end else begin
                    mon_exp  = rd_q.pop_front();
                    mon_name = rd_name_q.pop_front();
                    check(mon_name, o_rdata, mon_exp);
                end
            end
            if (o_wr_drop) begin
                checks++;
                if (drop_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wr_drop: got 1 want 0");
                end else begin
                    mon_name = drop_q.pop_front();
                end
            end
        end
    end

    // One cycle of stimulus; expectations are queued as the request is issued.
    task automatic access(input logic wr, input logic [ADDR-1:0] wa, input logic [31:0] wd,
                          input logic [NB-1:0] be, input logic full, input logic rd,
                          input logic [ADDR-1:0] ra, input logic [31:0] exp_rd,
                          input logic exp_drop, input logic clr, input string nm);
        i_write = wr;
        i_waddr = wa;
        i_wdata = wd;
        i_wbe   = be;
        i_wfull = full;
        i_read  = rd;
        i_raddr = ra;
        i_clear = clr;
        if (rd) begin
            rd_q.push_back(exp_rd);
            rd_name_q.push_back(nm);
        end
        if (exp_drop) drop_q.push_back(nm);
        @(posedge clk);
        #1;
        i_write = 1'b0;
        i_read  = 1'b0;
        i_clear = 1'b0;
        i_wfull = 1'b0;
    endtask

    task automatic wr(input logic [ADDR-1:0] a, input logic [31:0] d, input logic [NB-1:0] be,
                      input logic full, input logic exp_drop, input string nm);
        access(1'b1, a, d, be, full, 1'b0, '0, '0, exp_drop, 1'b0, nm);
    endtask

    task automatic rd(input logic [ADDR-1:0] a, input logic [31:0] exp, input string nm);
        access(1'b0, '0, '0, '0, 1'b0, 1'b1, a, exp, 1'b0, 1'b0, nm);
    endtask

    // Walks DEPTH edges checking init_done rises on exactly the last one.
    task automatic check_init(input string nm, input int inj_edge, input int rd_cycles);
        for (int k = 1; k <= DEPTH; k++) begin
            i_read  = (k <= rd_cycles);
            i_raddr = '0;
            i_write = (k == inj_edge);
            i_waddr = 5'd5;
            i_wdata = 32'hDEAD_BEEF;
            i_wbe   = '1;
            if (k == inj_edge) drop_q.push_back({nm, "_init_write"});
            @(posedge clk);
            #1;
            check($sformatf("%s_init_done_edge%0d", nm, k), 32'(o_init_done), 32'(k == DEPTH));
        end
        i_read  = 1'b0;
        i_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_init_done", 32'(o_init_done), 32'd0);
        check("rst_rvalid", 32'(o_rvalid), 32'd0);
        check("rst_wr_drop", 32'(o_wr_drop), 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        @(negedge clk);
        reset_b = 1'b1;
        check_init("boot", 5, 0);

        rd(5'd5, 32'h0000_0000, "rd5_after_drop");
        wr(5'd3, 32'hAABB_CCDD, 4'b0101, 1'b0, 1'b0, "wr3");
        rd(5'd3, 32'h00BB_00DD, "rd3_lanes");
        access(1'b1, 5'd7, 32'h1234_5678, 4'hF, 1'b0, 1'b1, 5'd7, 32'h1234_5678, 1'b0, 1'b0,
               "collide7_full");
        wr(5'd4, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, "wr4_wfull");
        rd(5'd4, 32'h0000_0000, "rd4_after_wfull");
        wr(5'd3, 32'h1111_1111, 4'h0, 1'b0, 1'b0, "wr3_be0");
        rd(5'd3, 32'h00BB_00DD, "rd3_after_be0");
        access(1'b1, 5'd3, 32'h9988_7766, 4'b1000, 1'b0, 1'b1, 5'd3, 32'h99BB_00DD, 1'b0, 1'b0,
               "collide3_lane3");
        rd(5'd7, 32'h1234_5678, "b2b_rd7");
        rd(5'd3, 32'h99BB_00DD, "b2b_rd3");

        for (int i = 0; i < DEPTH; i++) begin
            wr(ADDR'(i), 32'hC0DE_0000 | 32'(i), 4'hF, 1'b0, 1'b0, "fill");
        end
        rd(5'd0, 32'hC0DE_0000, "fill_rd0");
        rd(5'd17, 32'hC0DE_0011, "fill_rd17");
        rd(5'd31, 32'hC0DE_001F, "fill_rd31");
        access(1'b1, 5'd2, 32'hFFFF_FFFF, 4'hF, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, "wr_with_clear");
        check("clear_init_done_low", 32'(o_init_done), 32'd0);
        check_init("clear", 0, 5);
        for (int i = 0; i < DEPTH; i++) begin
            rd(ADDR'(i), 32'h0000_0000, $sformatf("cleared_rd%0d", i));
        end

        wr(5'd20, 32'h5A5A_5A5A, 4'hF, 1'b0, 1'b0, "wr20");
        rd(5'd20, 32'h5A5A_5A5A, "rd20");
        access(1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1, "clear2");
        repeat (9) @(posedge clk);
        #1;
        i_write = 1'b1;
        i_waddr = 5'd1;
        i_wbe   = '1;
        @(posedge clk);
        #1;
        i_write = 1'b0;
        check("midinit_rdata_hold", o_rdata, 32'h5A5A_5A5A);
        check("midinit_init_done", 32'(o_init_done), 32'd0);
        check("midinit_wr_drop", 32'(o_wr_drop), 32'd1);
        reset_b = 1'b0;
        #1;
        check("async_rst_rdata", o_rdata, 32'd0);
        check("async_rst_wr_drop", 32'(o_wr_drop), 32'd0);
        check("async_rst_rvalid", 32'(o_rvalid), 32'd0);
        check("async_rst_init_done", 32'(o_init_done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_b = 1'b1;
        check_init("rerst", 0, 0);
        rd(5'd20, 32'h0000_0000, "rd20_after_rerst");

        repeat (3) @(posedge clk);
        #1;
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("drop_q_drained", 32'(drop_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
